// File: rtl/jamma_pkg.sv
// jamma_pkg: scan state encoding, joystick bit indices and select decode shared by the JAMMA cores
package jamma_pkg;
  typedef logic [1:0] scan_state_t;
  localparam scan_state_t SEL1  = 2'd0;
  localparam scan_state_t SAMP1 = 2'd1;
  localparam scan_state_t SEL2  = 2'd2;
  localparam scan_state_t SAMP2 = 2'd3;
  localparam int JOY_UP    = 0;
  localparam int JOY_DOWN  = 1;
  localparam int JOY_LEFT  = 2;
  localparam int JOY_RIGHT = 3;
  localparam int JOY_FIRE1 = 4;
  localparam int JOY_FIRE2 = 5;
  localparam int JOY_START = 7;
  function automatic logic sel_of(input scan_state_t s);
    return s == SEL2 || s == SAMP2;
  endfunction
endpackage

// File: rtl/jamma_joy_scanner_if.sv
// jamma_joy_scanner_if: adapter bus, keyboard joystick and debounced outputs of the joystick scanner
interface jamma_joy_scanner_if;
  logic [7:0] jjoy;
  logic [1:0] jcoin;
  logic [5:0] kbd_joy;
  logic       jselect;
  logic [7:0] joy1;
  logic [7:0] joy2;
  logic [1:0] coin;
  logic       scan_done;
  modport master (input jjoy, jcoin, kbd_joy, output jselect, joy1, joy2, coin, scan_done);
  modport slave  (output jjoy, jcoin, kbd_joy, input jselect, joy1, joy2, coin, scan_done);
endinterface

// File: rtl/jamma_debounce_bit.sv
// jamma_debounce_bit: one active-low input bit that only changes after DEBOUNCE_COUNT consecutive differing samples
module jamma_debounce_bit #(
  parameter int DEBOUNCE_COUNT = 4
) (
  input  logic pclk,
  input  logic Reset_n,
  input  logic eval,
  input  logic raw,
  output logic stable
);
  localparam logic [3:0] THRESH = 4'(DEBOUNCE_COUNT);
  logic [3:0] cnt;
  always_ff @(posedge pclk or negedge Reset_n)
    if (!Reset_n) begin
      cnt    <= '0;
      stable <= 1'b1;
    end else if (eval) begin
      if (raw == stable) cnt <= '0;
      else if (cnt + 4'd1 == THRESH) begin
        stable <= raw;
        cnt    <= '0;
      end else cnt <= cnt + 4'd1;
    end
endmodule

// File: rtl/jamma_joy_scanner.sv
// jamma_joy_scanner: time-multiplexes the shared JJOY bus between two players, debounces joysticks and coins
module jamma_joy_scanner
  import jamma_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 8,
  parameter int DEBOUNCE_COUNT = 4
) (
  input logic               pclk,
  input logic               Reset_n,
  jamma_joy_scanner_if.master bus
);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  logic [7:0]  joy_m, joy_s, raw1, raw2;
  logic [1:0]  coin_m, coin_s, rawc;
  scan_state_t state, state_nx;
  logic [7:0]  cnt, cnt_nx;
  logic        in_sel, settled, jselect_q, eval1, done_q;
  logic [17:0] raw_all, eval_all, stable_all;
  always_ff @(posedge pclk or negedge Reset_n)
    if (!Reset_n) begin
      joy_m  <= '1;
      joy_s  <= '1;
      coin_m <= '1;
      coin_s <= '1;
    end else begin
      joy_m  <= bus.jjoy;
      joy_s  <= joy_m;
      coin_m <= bus.jcoin;
      coin_s <= coin_m;
    end
  // SEL states wait out the settle window; SAMP states last one cycle and advance unconditionally
  always_comb begin
    in_sel   = state == SEL1 || state == SEL2;
    settled  = cnt == SETTLE_LAST;
    cnt_nx   = (in_sel && !settled) ? cnt + 8'd1 : 8'd0;
    state_nx = (in_sel && !settled) ? state : scan_state_t'(state + 2'd1);
  end
  always_ff @(posedge pclk or negedge Reset_n)
    if (!Reset_n) begin
      state     <= SEL1;
      cnt       <= '0;
      jselect_q <= 1'b0;
      eval1     <= 1'b0;
      done_q    <= 1'b0;
      raw1      <= '1;
      raw2      <= '1;
      rawc      <= '1;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      jselect_q <= sel_of(state_nx);
      eval1     <= state == SAMP1;
      done_q    <= state == SAMP2;
      raw1      <= state == SAMP1 ? joy_s : raw1;
      rawc      <= state == SAMP1 ? coin_s : rawc;
      raw2      <= state == SAMP2 ? joy_s : raw2;
    end
  assign raw_all  = {rawc, raw2, raw1};
  assign eval_all = {{2{eval1}}, {8{done_q}}, {8{eval1}}};
  for (genvar i = 0; i < 18; i++) begin : g_db
    jamma_debounce_bit #(.DEBOUNCE_COUNT(DEBOUNCE_COUNT)) u_db (
      .pclk   (pclk),
      .Reset_n(Reset_n),
      .eval   (eval_all[i]),
      .raw    (raw_all[i]),
      .stable (stable_all[i])
    );
  end
  assign bus.jselect   = jselect_q;
  assign bus.joy1      = stable_all[7:0] & {2'b11, bus.kbd_joy};
  assign bus.joy2      = stable_all[15:8];
  assign bus.coin      = stable_all[17:16];
  assign bus.scan_done = done_q;
endmodule

// File: tb/tb_jamma_joy_scanner.sv
// tb_jamma_joy_scanner: random and directed per-scan stimulus against a sample-history debounce model with a scoreboard
module tb_jamma_joy_scanner;
  localparam int DC = 4;
  logic        pclk = 1'b0, Reset_n = 1'b1;
  logic [7:0]  p1 = 8'hFF, p2 = 8'hFF, jit_j = 8'h00;
  logic [1:0]  cv = 2'b11, jit_c = 2'b00;
  logic [5:0]  kbd = 6'h3F;
  logic        jit_en = 1'b0, mon_en = 1'b0, prev_done = 1'b0;
  int          cmp_cnt = 0, err_cnt = 0, cyc = 0, last_cyc = -1;
  logic [17:0] stb = '1, e;
  logic [17:0] expq[$], hist[$];
  int          last_flip[18];

  jamma_joy_scanner_if bus();
  assign bus.jjoy    = jit_en ? jit_j : (bus.jselect ? p2 : p1);
  assign bus.jcoin   = jit_en ? jit_c : cv;
  assign bus.kbd_joy = kbd;
  jamma_joy_scanner dut (.pclk(pclk), .Reset_n(Reset_n), .bus(bus));
  always #5 pclk = ~pclk;

  task automatic check(input string nm, input logic [17:0] act, input logic [17:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // a bit flips once its last DC samples since the previous flip all disagree with it
  task automatic model_step(input logic [17:0] s);
    int n;
    bit flip;
    hist.push_back(s);
    n = hist.size() - 1;
    for (int b = 0; b < 18; b++) begin
      flip = (n - last_flip[b]) >= DC;
      for (int i = 0; i < DC; i++) if (flip && hist[n-i][b] == stb[b]) flip = 0;
      if (flip) begin
        stb[b] = s[b];
        last_flip[b] = n;
      end
    end
    expq.push_back(stb);
  endtask

  task automatic wait_done(input string nm);
    int i;
    for (i = 0; i < 60; i++) begin
      @(negedge pclk);
      if (bus.scan_done === 1'b1) break;
    end
    if (i == 60) check(nm, 18'd0, 18'd1);
  endtask

  task automatic do_scan(input logic [7:0] a, input logic [7:0] b, input logic [1:0] c, input logic [5:0] k, input bit jit);
    wait_done("scan_done_wait");
    p1 = a; p2 = b; cv = c; kbd = k;
    #1;
    check("kbd_merge", {10'd0, bus.joy1}, {10'd0, stb[7:0] & {2'b11, k}});
    check("coin_mid", {16'd0, bus.coin}, {16'd0, stb[17:16]});
    model_step({c, b, a});
    if (jit)
      repeat (3) begin
        #($urandom_range(1, 8));
        jit_j = 8'($urandom);
        jit_c = 2'($urandom);
        jit_en = 1'b1;
        #($urandom_range(1, 8));
        jit_en = 1'b0;
      end
  endtask

  task automatic count_rise();
    int n = 0;
    while (n < 40) begin
      @(posedge pclk);
      #1;
      n++;
      if (bus.jselect) break;
    end
    check("jselect_rise", 18'(n), 18'd9);
  endtask

  task automatic check_reset_vals();
    check("rst_jselect", {17'd0, bus.jselect}, 18'd0);
    check("rst_joy1", {10'd0, bus.joy1}, 18'hFF);
    check("rst_joy2", {10'd0, bus.joy2}, 18'hFF);
    check("rst_coin", {16'd0, bus.coin}, 18'd3);
    check("rst_scan_done", {17'd0, bus.scan_done}, 18'd0);
  endtask

  always @(negedge pclk) begin
    if (!mon_en) begin
      prev_done = 1'b0;
      last_cyc = -1;
    end else begin
      if (prev_done) begin
        if (expq.size() == 0) check("sb_underflow", 18'd1, 18'd0);
        else begin
          e = expq.pop_front();
          check("joy1", {10'd0, bus.joy1}, {10'd0, e[7:0] & {2'b11, kbd}});
          check("joy2", {10'd0, bus.joy2}, {10'd0, e[15:8]});
          check("coin", {16'd0, bus.coin}, {16'd0, e[17:16]});
        end
      end
      if (bus.scan_done === 1'b1) begin
        if (last_cyc >= 0) check("scan_period", 18'(cyc - last_cyc), 18'd18);
        last_cyc = cyc;
      end
      prev_done = bus.scan_done;
    end
    cyc++;
  end

  initial begin
    logic [7:0] a, b;
    logic [1:0] c;
    logic [5:0] k;
    int h;
    bit jit;
    for (int i = 0; i < 18; i++) last_flip[i] = -1;
    #2 Reset_n = 1'b0;
    #1 check_reset_vals();
    repeat (3) @(negedge pclk);
    model_step(18'h3FFFF);
    mon_en = 1'b1;
    Reset_n = 1'b1;
    count_rise();
    repeat (5) do_scan(8'hFE, 8'hBF, 2'b11, 6'h3F, 0);
    repeat (4) do_scan(8'hFF, 8'hFF, 2'b11, 6'h3F, 0);
    repeat (3) do_scan(8'hFD, 8'hFF, 2'b11, 6'h3F, 0);
    repeat (4) do_scan(8'hFF, 8'hFF, 2'b11, 6'h3F, 0);
    repeat (5) do_scan(8'hFD, 8'hFF, 2'b11, 6'h3F, 0);
    repeat (4) do_scan(8'hFF, 8'hFF, 2'b11, 6'b111011, 0);
    repeat (5) do_scan(8'hFF, 8'hFF, 2'b10, 6'h3F, 0);
    repeat (5) do_scan(8'hFF, 8'hFF, 2'b11, 6'h3F, 0);
    do_scan(8'hFF, 8'hFF, 2'b10, 6'h3F, 0);
    repeat (4) do_scan(8'hFF, 8'hFF, 2'b11, 6'h3F, 0);
    for (int r = 0; r < 20; r++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      c = 2'($urandom);
      k = $urandom_range(0, 3) == 0 ? 6'($urandom) : 6'h3F;
      h = $urandom_range(1, 6);
      jit = 1'($urandom);
      repeat (h) do_scan(a, b, c, k, jit);
    end
    repeat (5) do_scan(8'h00, 8'h00, 2'b00, 6'h3F, 1);
    wait_done("drain_wait");
    repeat (2) @(negedge pclk);
    check("drain", 18'(expq.size()), 18'd0);
    mon_en = 1'b0;
    begin
      int i;
      for (i = 0; i < 40; i++) begin
        @(negedge pclk);
        if (bus.jselect) break;
      end
      check("reach_sel2", {17'd0, bus.jselect}, 18'd1);
    end
    #2 Reset_n = 1'b0;
    #1 check_reset_vals();
    repeat (3) @(negedge pclk);
    Reset_n = 1'b1;
    count_rise();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
